sc_lane_scheduler: RTL and testbench



---
 rtl/sc_lane_scheduler.sv | 170 +++++++++++++++++
 tb/tb_sc_lane_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc_lane_scheduler.sv
// Frogger traffic-lane scheduler: follows game state, derives a level-scaled tick and
// round-robin grants one lane shift per clock. Optional pause input: SC_LANE_SCHEDULER_PAUSE_EN.
module sc_lane_scheduler #(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned PRESCALE_WIDTH = 24,
    parameter int unsigned BASE_PERIOD    = 5000000,
    parameter int unsigned LEVEL_WIDTH    = 2
) (
    input  logic                   SC_LANE_SCHEDULER_CLOCK_50,
    input  logic                   SC_LANE_SCHEDULER_RESET_InLow,
    input  logic [1:0]             SC_LANE_SCHEDULER_GameState_In,
    input  logic                   SC_LANE_SCHEDULER_LevelUp_In,
`ifdef SC_LANE_SCHEDULER_PAUSE_EN
    input  logic                   SC_LANE_SCHEDULER_Pause_InLow,
`endif
    output logic                   SC_LANE_SCHEDULER_LoadSignal_Out,
    output logic [NUM_LANES-1:0]   SC_LANE_SCHEDULER_ShiftLane_Out,
    output logic [LEVEL_WIDTH-1:0] SC_LANE_SCHEDULER_Level_Out,
    output logic                   SC_LANE_SCHEDULER_Overrun_Out
);

    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [PRESCALE_WIDTH-1:0] BASE_P    = PRESCALE_WIDTH'(BASE_PERIOD);
    localparam logic [LEVEL_WIDTH-1:0]    LEVEL_MAX = '1;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_LOAD   = 2'b01;
    localparam logic [1:0] ST_RUN    = 2'b10;
    localparam logic [1:0] ST_FREEZE = 2'b11;

    localparam logic [1:0] GS_PLAY = 2'b01;
    localparam logic [1:0] GS_END  = 2'b10;

    logic [1:0] game_state;
    assign game_state = SC_LANE_SCHEDULER_GameState_In;

    logic [1:0] state, state_next;

    logic [PRESCALE_WIDTH-1:0]              prescale_q, prescale_d;
    logic [NUM_LANES-1:0][LANE_W-1:0]       lane_cnt_q, lane_cnt_d;
    logic [NUM_LANES-1:0]                   pending_q, pending_d;
    logic [LANE_W-1:0]                      rr_q, rr_d;
    logic [LEVEL_WIDTH-1:0]                 level_q, level_d;
    logic                                   overrun_q, overrun_d;
    logic [NUM_LANES-1:0]                   shift_q, shift_d;
    logic                                   load_q, load_d;

    logic                      paused_c, run_c, stay_c, tick_c, level_up_c, found_c;
    logic [PRESCALE_WIDTH-1:0] period_c;
    logic [NUM_LANES-1:0]      due_c, grant_c;
    int                        gidx_c, idx_c;

    // State register
    always_ff @(posedge SC_LANE_SCHEDULER_CLOCK_50 or negedge SC_LANE_SCHEDULER_RESET_InLow) begin
        if (!SC_LANE_SCHEDULER_RESET_InLow) state <= ST_IDLE;
        else                                state <= state_next;
    end

    // Next-state logic; code 11 on the game-state bus behaves like await
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (game_state == GS_PLAY) state_next = ST_LOAD;
            ST_LOAD:   state_next = ST_RUN;
            ST_RUN: begin
                if (game_state == GS_END)       state_next = ST_FREEZE;
                else if (game_state != GS_PLAY) state_next = ST_IDLE;
            end
            ST_FREEZE: if (game_state != GS_PLAY && game_state != GS_END) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Tick, lane scheduling and round-robin arbitration
    always_comb begin
`ifdef SC_LANE_SCHEDULER_PAUSE_EN
        paused_c = !SC_LANE_SCHEDULER_Pause_InLow;
`else
        paused_c = 1'b0;
`endif
        period_c   = BASE_P >> level_q;
        run_c      = (state == ST_RUN) && !paused_c;
        stay_c     = run_c && (state_next == ST_RUN);
        tick_c     = run_c && (prescale_q == period_c - PRESCALE_WIDTH'(1));
        level_up_c = run_c && SC_LANE_SCHEDULER_LevelUp_In && (level_q != LEVEL_MAX);

        due_c = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            due_c[i] = tick_c && (lane_cnt_q[i] == LANE_W'(i));
        end

        found_c = 1'b0;
        gidx_c  = 0;
        idx_c   = 0;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            idx_c = int'(rr_q) + k;
            if (idx_c >= int'(NUM_LANES)) idx_c = idx_c - int'(NUM_LANES);
            if (!found_c && pending_q[LANE_W'(idx_c)]) begin
                found_c = 1'b1;
                gidx_c  = idx_c;
            end
        end
        grant_c = '0;
        if (found_c && stay_c) grant_c[LANE_W'(gidx_c)] = 1'b1;

        prescale_d = prescale_q;
        lane_cnt_d = lane_cnt_q;
        pending_d  = pending_q;
        rr_d       = rr_q;
        level_d    = level_q;
        overrun_d  = overrun_q;
        shift_d    = grant_c;
        load_d     = (state_next == ST_LOAD);

        if (state_next == ST_LOAD) begin
            prescale_d = '0;
            lane_cnt_d = '0;
            pending_d  = '0;
            rr_d       = '0;
            level_d    = '0;
            overrun_d  = 1'b0;
        end else begin
            if (run_c) begin
                if (tick_c || level_up_c) prescale_d = '0;
                else                      prescale_d = prescale_q + PRESCALE_WIDTH'(1);
            end
            if (level_up_c) level_d = level_q + LEVEL_WIDTH'(1);
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (tick_c) begin
                    if (due_c[i]) lane_cnt_d[i] = '0;
                    else          lane_cnt_d[i] = lane_cnt_q[i] + LANE_W'(1);
                end
            end
            // A lane granted on the same edge it becomes due is not an overrun
            overrun_d = overrun_q | (|(due_c & pending_q & ~grant_c));
            if (state == ST_RUN && state_next != ST_RUN) pending_d = '0;
            else                                          pending_d = (pending_q & ~grant_c) | due_c;
            if (found_c && stay_c) rr_d = LANE_W'((gidx_c + 1) % int'(NUM_LANES));
        end
    end

    // Datapath and output registers
    always_ff @(posedge SC_LANE_SCHEDULER_CLOCK_50 or negedge SC_LANE_SCHEDULER_RESET_InLow) begin
        if (!SC_LANE_SCHEDULER_RESET_InLow) begin
            prescale_q <= '0;
            lane_cnt_q <= '0;
            pending_q  <= '0;
            rr_q       <= '0;
            level_q    <= '0;
            overrun_q  <= 1'b0;
            shift_q    <= '0;
            load_q     <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            lane_cnt_q <= lane_cnt_d;
            pending_q  <= pending_d;
            rr_q       <= rr_d;
            level_q    <= level_d;
            overrun_q  <= overrun_d;
            shift_q    <= shift_d;
            load_q     <= load_d;
        end
    end

    assign SC_LANE_SCHEDULER_LoadSignal_Out = load_q;
    assign SC_LANE_SCHEDULER_ShiftLane_Out  = shift_q;
    assign SC_LANE_SCHEDULER_Level_Out      = level_q;
    assign SC_LANE_SCHEDULER_Overrun_Out    = overrun_q;

endmodule

// File: tb/tb_sc_lane_scheduler.sv
// Self-checking bench for sc_lane_scheduler (BASE_PERIOD=16): scoreboard of expected
// shift grants with exact cycle, plus level, freeze and reset checks.
module tb_sc_lane_scheduler;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] gs    = 2'b00;
    logic       lu    = 1'b0;
`ifdef SC_LANE_SCHEDULER_PAUSE_EN
    logic       pause_n = 1'b1;
`endif
    logic       load;
    logic [3:0] shift;
    logic [1:0] level;
    logic       ovr;

    sc_lane_scheduler #(
        .NUM_LANES      (4),
        .PRESCALE_WIDTH (24),
        .BASE_PERIOD    (16),
        .LEVEL_WIDTH    (2)
    ) dut (
`ifdef SC_LANE_SCHEDULER_PAUSE_EN
        .SC_LANE_SCHEDULER_Pause_InLow    (pause_n),
`endif
        .SC_LANE_SCHEDULER_CLOCK_50       (clk),
        .SC_LANE_SCHEDULER_RESET_InLow    (rst_n),
        .SC_LANE_SCHEDULER_GameState_In   (gs),
        .SC_LANE_SCHEDULER_LevelUp_In     (lu),
        .SC_LANE_SCHEDULER_LoadSignal_Out (load),
        .SC_LANE_SCHEDULER_ShiftLane_Out  (shift),
        .SC_LANE_SCHEDULER_Level_Out      (level),
        .SC_LANE_SCHEDULER_Overrun_Out    (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [3:0] oh;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    bit   mon_en = 1'b0;
    int   n_tick = 0;
    int   rr     = 0;

    // Expected grants for one tick whose pending-set edge is t: due lanes served round-robin
    task automatic push_tick(input int t);
        logic [3:0] due;
        exp_t       e;
        int         k;
        int         pick;
        bit         found;
        n_tick++;
        for (int i = 0; i < 4; i++) due[i] = ((n_tick % (i + 1)) == 0);
        k = 0;
        for (int g = 0; g < 4; g++) begin
            found = 1'b0;
            pick  = 0;
            for (int s = 0; s < 4; s++) begin
                if (!found && due[(rr + s) % 4]) begin
                    found = 1'b1;
                    pick  = (rr + s) % 4;
                end
            end
            if (found) begin
                due[pick] = 1'b0;
                e.cyc = t + 1 + k;
                e.oh  = 4'(1 << pick);
                sb_q.push_back(e);
                k++;
                rr = (pick + 1) % 4;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && shift !== 4'b0000) begin
            if (sb_q.size() == 0) begin
                chk("sb_extra", 32'(shift), 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_lane", 32'(shift), 32'(sb_e.oh));
                chk("sb_cycle", 32'(cyc), 32'(sb_e.cyc));
            end
        end
    end

    task automatic wait_until(input int v);
        while (cyc < v) @(negedge clk);
    endtask

    int base;
    int lbase;
    bit seen;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_shift", 32'(shift), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_load", 32'(load), 32'd0);

        // Game start: one LOAD cycle, then 12 ticks at level 0 (period 16)
        gs = 2'b01;
        @(negedge clk);
        chk("load_pulse", 32'(load), 32'd1);
        chk("load_shift", 32'(shift), 32'd0);
        chk("load_level", 32'(level), 32'd0);
        base = cyc + 1;
        for (int n = 1; n <= 12; n++) push_tick(base + 16 * n);
        mon_en = 1'b1;
        @(negedge clk);
        chk("load_once", 32'(load), 32'd0);
        wait_until(base + 16 * 12 + 6);
        chk("l0_drain", 32'(sb_q.size()), 32'd0);
        chk("l0_ovr", 32'(ovr), 32'd0);

        // Level 1: prescaler restarts, period 8
        lu    = 1'b1;
        lbase = cyc + 1;
        for (int m = 1; m <= 12; m++) push_tick(lbase + 8 * m);
        @(negedge clk);
        lu = 1'b0;
        chk("lvl1", 32'(level), 32'd1);
        wait_until(lbase + 8 * 12 + 6);
        chk("l1_drain", 32'(sb_q.size()), 32'd0);
        chk("l1_ovr", 32'(ovr), 32'd0);
        mon_en = 1'b0;

        lu = 1'b1;
        @(negedge clk);
        lu = 1'b0;
        chk("lvl2", 32'(level), 32'd2);
        repeat (40) @(negedge clk);
        lu = 1'b1;
        @(negedge clk);
        lu = 1'b0;
        chk("lvl3", 32'(level), 32'd3);
        repeat (140) @(negedge clk);
        chk("p2_ovr", 32'(ovr), 32'd1);
        lu = 1'b1;
        @(negedge clk);
        lu = 1'b0;
        chk("lvl_sat", 32'(level), 32'd3);

        // End of game during a grant burst
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (shift !== 4'b0000) seen = 1'b1;
            else @(negedge clk);
        end
        chk("burst_seen", 32'(seen), 32'd1);
        gs = 2'b10;
        repeat (8) begin
            @(negedge clk);
            chk("frz_shift", 32'(shift), 32'd0);
        end
        chk("frz_level", 32'(level), 32'd3);
        chk("frz_ovr", 32'(ovr), 32'd1);
        gs = 2'b01;
        repeat (4) begin
            @(negedge clk);
            chk("frz_noload", 32'(load), 32'd0);
        end
        chk("frz_play_shift", 32'(shift), 32'd0);
        gs = 2'b00;
        repeat (2) @(negedge clk);
        gs = 2'b01;
        @(negedge clk);
        chk("reload_pulse", 32'(load), 32'd1);
        chk("reload_level", 32'(level), 32'd0);
        chk("reload_ovr", 32'(ovr), 32'd0);
        @(negedge clk);
        chk("reload_once", 32'(load), 32'd0);

        // Asynchronous reset between edges while running
        repeat (25) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        gs    = 2'b00;
        #1;
        chk("arst_load", 32'(load), 32'd0);
        chk("arst_shift", 32'(shift), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_ovr", 32'(ovr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("arst_noload", 32'(load), 32'd0);
        end
        gs = 2'b01;
        @(negedge clk);
        chk("arst_load_again", 32'(load), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
